// File: rtl/pss_search_pkg.sv
// Shared types and constants for the PSS search controller and its peak tracker.
// The state encoding is visible on state_o, so the enum values are fixed.
package pss_search_pkg;

    localparam int N_CORR = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_TRACK   = 2'd3
    } state_e;

    localparam logic [N_CORR-1:0] CORR_ALL = {N_CORR{1'b1}};

    // One-hot correlator enable for a single N_ID_2 index.
    function automatic logic [N_CORR-1:0] corr_onehot(input logic [1:0] idx);
        corr_onehot = {{(N_CORR-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/pss_peak_tracker.sv
// Three-way argmax of correlator scores plus a running maximum register.
// nxt_* shows the running max after this sample's update, even when clear is also asserted.
module pss_peak_tracker
    import pss_search_pkg::*;
#(
    parameter int IN_DW = 24,
    parameter int POS_W = 15
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    update,
    input  logic [N_CORR-1:0]       mask,
    input  logic [N_CORR*IN_DW-1:0] scores,
    input  logic [IN_DW-1:0]        threshold,
    input  logic [POS_W-1:0]        pos,
    output logic                    hit,
    output logic                    nxt_valid,
    output logic [IN_DW-1:0]        nxt_val,
    output logic [1:0]              nxt_idx,
    output logic [POS_W-1:0]        nxt_pos
);

    logic [IN_DW-1:0] masked [N_CORR];
    logic [IN_DW-1:0] arg_val;
    logic [1:0]       arg_idx;
    logic             cand_ok;

    logic             max_valid_reg;
    logic [IN_DW-1:0] max_val_reg;
    logic [1:0]       max_idx_reg;
    logic [POS_W-1:0] max_pos_reg;

    generate
        for (genvar gi = 0; gi < N_CORR; gi++) begin : g_mask
            assign masked[gi] = mask[gi] ? scores[gi*IN_DW +: IN_DW] : '0;
        end
    endgenerate

    // Scanning upward and replacing only on strictly greater keeps the lowest index on ties.
    always_comb begin
        arg_val = masked[0];
        arg_idx = 2'd0;
        for (int k = 1; k < N_CORR; k++) begin
            if (masked[k] > arg_val) begin
                arg_val = masked[k];
                arg_idx = 2'(k);
            end
        end
    end

    assign hit     = (arg_val > threshold);
    assign cand_ok = hit && (!max_valid_reg || (arg_val > max_val_reg));

    assign nxt_valid = max_valid_reg | cand_ok;
    assign nxt_val   = cand_ok ? arg_val : max_val_reg;
    assign nxt_idx   = cand_ok ? arg_idx : max_idx_reg;
    assign nxt_pos   = cand_ok ? pos     : max_pos_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            max_valid_reg <= 1'b0;
            max_val_reg   <= '0;
            max_idx_reg   <= '0;
            max_pos_reg   <= '0;
        end else if (load) begin
            max_valid_reg <= 1'b1;
            max_val_reg   <= arg_val;
            max_idx_reg   <= arg_idx;
            max_pos_reg   <= pos;
        end else if (update) begin
            max_valid_reg <= nxt_valid;
            max_val_reg   <= nxt_val;
            max_idx_reg   <= nxt_idx;
            max_pos_reg   <= nxt_pos;
        end
    end

endmodule

// File: rtl/pss_search_ctrl.sv
// PSS search/confirm/track controller: finds the strongest N_ID_2 correlator peak,
// then follows it frame by frame in a narrow window until MISS_MAX windows in a row are empty.
module pss_search_ctrl
    import pss_search_pkg::*;
#(
    parameter int IN_DW       = 24,
    parameter int FRAME_LEN   = 19200,
    parameter int PEAK_WINDOW = 8,
    parameter int TRACK_WIN   = 16,
    parameter int MISS_MAX    = 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic [IN_DW-1:0]               threshold_i,
    input  logic [N_CORR*IN_DW-1:0]        s_axis_in_tdata,
    input  logic                           s_axis_in_tvalid,
    output logic [N_CORR-1:0]              corr_en_o,
    output logic                           detect_o,
    output logic                           lost_o,
    output logic [1:0]                     N_id_2_o,
    output logic [$clog2(FRAME_LEN)-1:0]   peak_pos_o,
    output logic [IN_DW-1:0]               peak_val_o,
    output logic [1:0]                     state_o
);

    localparam int CW    = $clog2(FRAME_LEN);
    localparam int PWC_W = $clog2(PEAK_WINDOW + 1);
    localparam int WC_W  = $clog2(2*TRACK_WIN + 2);
    localparam int MW    = $clog2(MISS_MAX + 1);

    localparam logic [CW-1:0]    CNT_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]    TW_C      = CW'(TRACK_WIN);
    localparam logic [CW-1:0]    FL_M_TW   = CW'(FRAME_LEN - TRACK_WIN);
    localparam logic [PWC_W-1:0] PW_LAST   = PWC_W'(PEAK_WINDOW - 1);
    localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(2*TRACK_WIN);
    localparam logic [MW-1:0]    MISS_LAST = MW'(MISS_MAX - 1);

    generate
        if (!(PEAK_WINDOW + TRACK_WIN < FRAME_LEN) || !(2*TRACK_WIN + 1 < FRAME_LEN) ||
            (PEAK_WINDOW < 1) || (MISS_MAX < 1)) begin : g_bad_params
            $error("pss_search_ctrl: PEAK_WINDOW/TRACK_WIN/MISS_MAX do not fit FRAME_LEN");
        end
    endgenerate

    // Window start (exp - TRACK_WIN) mod FRAME_LEN; both branches stay below FRAME_LEN.
    function automatic logic [CW-1:0] open_pos(input logic [CW-1:0] e);
        return (e >= TW_C) ? (e - TW_C) : (e + FL_M_TW);
    endfunction

    state_e             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next, cnt_inc;
    logic [PWC_W-1:0]   pw_cnt_reg, pw_cnt_next;
    logic [WC_W-1:0]    win_cnt_reg, win_cnt_next;
    logic               win_open_reg, win_open_next;
    logic [MW-1:0]      miss_reg, miss_next;
    logic [CW-1:0]      exp_reg, exp_next;
    logic [N_CORR-1:0]  corr_en_reg, corr_en_next;
    logic               detect_reg, detect_next;
    logic               lost_reg, lost_next;
    logic [1:0]         nid_reg, nid_next;
    logic [CW-1:0]      pos_reg, pos_next;
    logic [IN_DW-1:0]   val_reg, val_next;

    logic               trk_clear, trk_load, trk_update;
    logic [N_CORR-1:0]  trk_mask;
    logic               trk_hit, trk_nxt_valid;
    logic [IN_DW-1:0]   trk_nxt_val;
    logic [1:0]         trk_nxt_idx;
    logic [CW-1:0]      trk_nxt_pos;

    pss_peak_tracker #(
        .IN_DW (IN_DW),
        .POS_W (CW)
    ) u_tracker (
        .clk       (clk_i),
        .srst      (reset_i),
        .clear     (trk_clear),
        .load      (trk_load),
        .update    (trk_update),
        .mask      (trk_mask),
        .scores    (s_axis_in_tdata),
        .threshold (threshold_i),
        .pos       (cnt_reg),
        .hit       (trk_hit),
        .nxt_valid (trk_nxt_valid),
        .nxt_val   (trk_nxt_val),
        .nxt_idx   (trk_nxt_idx),
        .nxt_pos   (trk_nxt_pos)
    );

    assign cnt_inc = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pw_cnt_next   = pw_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        win_open_next = win_open_reg;
        miss_next     = miss_reg;
        exp_next      = exp_reg;
        nid_next      = nid_reg;
        pos_next      = pos_reg;
        val_next      = val_reg;
        detect_next   = 1'b0;
        lost_next     = 1'b0;
        trk_clear     = 1'b0;
        trk_load      = 1'b0;
        trk_update    = 1'b0;
        trk_mask      = CORR_ALL;

        if (!enable_i) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            pw_cnt_next   = '0;
            win_cnt_next  = '0;
            win_open_next = 1'b0;
            miss_next     = '0;
            trk_clear     = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_SEARCH;
                    cnt_next   = '0;
                    trk_clear  = 1'b1;
                end

                ST_SEARCH: begin
                    if (s_axis_in_tvalid) begin
                        cnt_next = cnt_inc;
                        if (trk_hit) begin
                            trk_load    = 1'b1;
                            pw_cnt_next = '0;
                            state_next  = ST_CONFIRM;
                        end else begin
                            trk_clear = 1'b1;
                        end
                    end
                end

                ST_CONFIRM: begin
                    if (s_axis_in_tvalid) begin
                        cnt_next   = cnt_inc;
                        trk_update = 1'b1;
                        if (pw_cnt_reg == PW_LAST) begin
                            detect_next   = 1'b1;
                            nid_next      = trk_nxt_idx;
                            pos_next      = trk_nxt_pos;
                            val_next      = trk_nxt_val;
                            exp_next      = trk_nxt_pos;
                            miss_next     = '0;
                            pw_cnt_next   = '0;
                            win_cnt_next  = '0;
                            trk_clear     = 1'b1;
                            state_next    = ST_TRACK;
                            win_open_next = (cnt_inc == open_pos(trk_nxt_pos));
                        end else begin
                            pw_cnt_next = pw_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_TRACK: begin
                    trk_mask = corr_onehot(nid_reg);
                    if (s_axis_in_tvalid) begin
                        cnt_next = cnt_inc;
                        if (win_open_reg) begin
                            trk_update = 1'b1;
                            if (win_cnt_reg == WIN_LAST) begin
                                win_cnt_next = '0;
                                trk_clear    = 1'b1;
                                if (trk_nxt_valid) begin
                                    detect_next = 1'b1;
                                    pos_next    = trk_nxt_pos;
                                    val_next    = trk_nxt_val;
                                    exp_next    = trk_nxt_pos;
                                    miss_next   = '0;
                                end else if (miss_reg == MISS_LAST) begin
                                    lost_next  = 1'b1;
                                    miss_next  = '0;
                                    state_next = ST_SEARCH;
                                end else begin
                                    miss_next = miss_reg + 1'b1;
                                end
                                win_open_next = (state_next == ST_TRACK) &&
                                                (cnt_inc == open_pos(exp_next));
                            end else begin
                                win_cnt_next = win_cnt_reg + 1'b1;
                            end
                        end else begin
                            trk_clear     = 1'b1;
                            win_open_next = (cnt_inc == open_pos(exp_reg));
                        end
                    end
                end
            endcase
        end

        // win_open_next means "the next sample lies in the window", so the
        // correlator is already enabled when the first window sample arrives.
        corr_en_next = '0;
        if ((state_next == ST_SEARCH) || (state_next == ST_CONFIRM)) begin
            corr_en_next = CORR_ALL;
        end else if ((state_next == ST_TRACK) && win_open_next) begin
            corr_en_next = corr_onehot(nid_next);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            pw_cnt_reg   <= '0;
            win_cnt_reg  <= '0;
            win_open_reg <= 1'b0;
            miss_reg     <= '0;
            exp_reg      <= '0;
            corr_en_reg  <= '0;
            detect_reg   <= 1'b0;
            lost_reg     <= 1'b0;
            nid_reg      <= '0;
            pos_reg      <= '0;
            val_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pw_cnt_reg   <= pw_cnt_next;
            win_cnt_reg  <= win_cnt_next;
            win_open_reg <= win_open_next;
            miss_reg     <= miss_next;
            exp_reg      <= exp_next;
            corr_en_reg  <= corr_en_next;
            detect_reg   <= detect_next;
            lost_reg     <= lost_next;
            nid_reg      <= nid_next;
            pos_reg      <= pos_next;
            val_reg      <= val_next;
        end
    end

    assign corr_en_o  = corr_en_reg;
    assign detect_o   = detect_reg;
    assign lost_o     = lost_reg;
    assign N_id_2_o   = nid_reg;
    assign peak_pos_o = pos_reg;
    assign peak_val_o = val_reg;
    assign state_o    = state_reg;

endmodule

// File: doc/pss_search_ctrl.md
PSS_SEARCH_CTRL -- requirements
Module: pss_search_ctrl

Interface
REQ-001 Parameter IN_DW, default 24: width of one correlator score.
REQ-002 Parameter FRAME_LEN, default 19200: samples between consecutive PSS occurrences.
REQ-003 Parameter PEAK_WINDOW, default 8: samples searched after the first threshold crossing.
REQ-004 Parameter TRACK_WIN, default 16: half-width of the tracking window, in samples.
REQ-005 Parameter MISS_MAX, default 3: consecutive missed windows before lock is declared lost.
REQ-006 Port clk_i, input, 1: the single clock; every output is registered to it.
REQ-007 Port reset_i, input, 1: synchronous, active-high reset.
REQ-008 Port enable_i, input, 1: run request; when low the block is held in IDLE.
REQ-009 Port threshold_i, input, IN_DW: unsigned detection threshold, sampled every cycle.
REQ-010 Port s_axis_in_tdata, input, 3*IN_DW: unsigned scores; slice k (bits k*IN_DW upward) is the score for N_ID_2=k.
REQ-011 Port s_axis_in_tvalid, input, 1: score valid; one sample per asserted cycle.
REQ-012 Port corr_en_o, output, 3: per-correlator enable, bit k drives correlator N_ID_2=k.
REQ-013 Port detect_o, output, 1: one-cycle pulse when a peak is confirmed.
REQ-014 Port lost_o, output, 1: one-cycle pulse when lock is lost.
REQ-015 Ports N_id_2_o (2 bits), peak_pos_o ($clog2(FRAME_LEN) bits), peak_val_o (IN_DW bits), outputs: the last confirmed peak, held between detections.
REQ-016 Port state_o, output, 2: current state, encoded IDLE=0, SEARCH=1, CONFIRM=2, TRACK=3.

Function
REQ-017 Sample counter cnt increments by one on each valid sample, wraps from FRAME_LEN-1 to 0, and is cleared to 0 in IDLE.
REQ-018 Only cycles with s_axis_in_tvalid=1 advance cnt, window counters or the FSM; other cycles hold all state.
REQ-019 IDLE: corr_en_o=000; move to SEARCH on the first cycle with enable_i=1.
REQ-020 SEARCH: corr_en_o=111; move to CONFIRM on any score strictly greater than threshold_i, recording the score, its index and cnt as the running max.
REQ-021 Argmax rule: the largest score wins; on equal scores the lowest index wins; the running max is replaced only by a strictly greater score.
REQ-022 CONFIRM: corr_en_o=111; update the running max over the next PEAK_WINDOW valid samples.
REQ-023 End of CONFIRM: pulse detect_o, load the N_id_2_o/peak_pos_o/peak_val_o outputs, set expected position exp=peak_pos, clear the miss counter, and enter TRACK.
REQ-024 TRACK: the window opens at cnt == (exp-TRACK_WIN) mod FRAME_LEN and lasts 2*TRACK_WIN+1 valid samples, wrap-aware.
REQ-025 In TRACK, corr_en_o has only bit N_id_2_o set, and only while the window is open; otherwise corr_en_o=000.
REQ-026 In-window max: only the locked index's score is considered, using strict > threshold_i and strict > running max.
REQ-027 Window close with a peak found: pulse detect_o, update outputs, set exp to the new position, clear misses.
REQ-028 Window close with no peak: increment misses; when misses reach MISS_MAX, pulse lost_o, clear misses, and go to SEARCH on the next cycle.
REQ-029 corr_en_o is registered and changes one cycle after the state or window change that causes it.
REQ-030 enable_i=0 in any state: next cycle enter IDLE with corr_en_o=000; the held peak outputs keep their values.
REQ-031 detect_o and lost_o are never asserted in the same cycle.
REQ-032 Score comparisons are unsigned at IN_DW bits, and no arithmetic truncates.
REQ-033 Elaboration shall fail unless PEAK_WINDOW+TRACK_WIN < FRAME_LEN and 2*TRACK_WIN+1 < FRAME_LEN.

Reset
REQ-034 reset_i=1 at a clock edge: state IDLE, all counters 0, all outputs 0; this overrides enable_i and s_axis_in_tvalid.
REQ-035 Reset asserted mid-CONFIRM or mid-window discards any partial result, and no detect_o is emitted.

Structure
REQ-036 Package pss_search_pkg holds the state enum, N_CORR=3 and the state encoding.
REQ-037 One sub-module, pss_peak_tracker, holds the 3-way argmax and the running max with clear/load/update controls.
REQ-038 The top level contains the FSM, the sample counter and the window/miss counters.

Verification (FRAME_LEN=64, PEAK_WINDOW=4, TRACK_WIN=2, MISS_MAX=2, threshold=100, scores 0 unless stated)
REQ-039 Search hit: score1=150 at cnt 10, then 180 at cnt 12 -> detect_o pulse with N_id_2_o=1, peak_pos_o=12, peak_val_o=180, state_o=TRACK.
REQ-040 Tie and equality: score0=score2=120 at the same sample -> N_id_2_o=0; a score exactly equal to 100 alone -> no detection.
REQ-041 Tracking: after lock at pos 12, feed peak 200 at cnt 13 of the next frame -> window cnt 10..14, corr_en_o=010 only inside it, detect_o, peak_pos_o=13.
REQ-042 Loss: after lock, two empty windows -> lost_o pulse after the 2nd window, state SEARCH, corr_en_o=111.
REQ-043 Wrap: lock at pos 63 -> next window covers cnt 61,62,63,0,1, and a peak at cnt 0 is detected with peak_pos_o=0.
REQ-044 Reset and disable: reset_i mid-CONFIRM -> all outputs 0 and no detect_o; enable_i=0 in TRACK -> IDLE next cycle with corr_en_o=000.
